// File: rtl/tensor_burst_sequencer_pkg.sv
// Shared types and sizing helpers for the tensor burst sequencer slice.
package tensor_pkg;

  typedef enum logic [1:0] {
    CMD_READ    = 2'd0,
    CMD_WRITE   = 2'd1,
    CMD_RDWR    = 2'd2,
    CMD_OPERATE = 2'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_RDWR    = 3'd3,
    ST_COMPUTE = 3'd4,
    ST_COMMIT  = 3'd5
  } seq_state_t;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // Index width that never collapses to zero bits for single-beat bursts.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tensor_burst_sequencer_if.sv
// Command, write, read and core-control channels of the burst sequencer.
interface tensor_burst_sequencer_if #(
  parameter int unsigned N           = 3,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WRITE_LANES = 4,
  parameter int unsigned READ_LANES  = 2
);
  localparam int unsigned WB = tensor_pkg::ceil_div(2 * N * N, WRITE_LANES);
  localparam int unsigned BW = tensor_pkg::idx_width(WB);

  logic                              cmd_valid_in;
  logic                              cmd_ready_out;
  logic [1:0]                        cmd_op_in;
  logic [2:0]                        cmd_select_in;
  logic                              abort_in;
  logic                              write_data_valid_in;
  logic                              write_data_ready_out;
  logic [WRITE_LANES*DATA_WIDTH-1:0] write_data_in;
  logic                              rf_write_enable_out;
  logic [BW-1:0]                     rf_write_beat_out;
  logic [WRITE_LANES-1:0]            rf_write_lane_mask_out;
  logic [WRITE_LANES*DATA_WIDTH-1:0] rf_write_data_out;
  logic [N*N*DATA_WIDTH-1:0]         result_in;
  logic                              read_data_valid_out;
  logic                              read_data_ready_in;
  logic [READ_LANES*DATA_WIDTH-1:0]  read_data_out;
  logic                              core_start_out;
  logic [2:0]                        core_select_out;
  logic                              bulk_write_enable_out;
  logic                              busy_out;

  modport slave (
    input  cmd_valid_in, cmd_op_in, cmd_select_in, abort_in,
           write_data_valid_in, write_data_in, result_in, read_data_ready_in,
    output cmd_ready_out, write_data_ready_out, rf_write_enable_out, rf_write_beat_out,
           rf_write_lane_mask_out, rf_write_data_out, read_data_valid_out, read_data_out,
           core_start_out, core_select_out, bulk_write_enable_out, busy_out
  );

  modport master (
    output cmd_valid_in, cmd_op_in, cmd_select_in, abort_in,
           write_data_valid_in, write_data_in, result_in, read_data_ready_in,
    input  cmd_ready_out, write_data_ready_out, rf_write_enable_out, rf_write_beat_out,
           rf_write_lane_mask_out, rf_write_data_out, read_data_valid_out, read_data_out,
           core_start_out, core_select_out, bulk_write_enable_out, busy_out
  );

endinterface

// File: rtl/tensor_burst_sequencer_beat_counter.sv
// Saturating beat counter: counts enabled beats up to LIMIT and flags completion.
module burst_beat_counter #(
  parameter  int unsigned LIMIT = 5,
  localparam int unsigned CW    = $clog2(LIMIT + 1)
) (
  input  logic          clock_in,
  input  logic          reset_in,
  input  logic          enable_in,
  input  logic          clear_in,
  output logic [CW-1:0] count_out,
  output logic          done_out
);

  logic [CW-1:0] count_q, count_d;

  assign done_out  = (count_q == CW'(LIMIT));
  assign count_out = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_in) begin
      count_d = '0;
    end else if (enable_in && !done_out) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tensor_burst_sequencer.sv
// Sequences matrix burst writes, result burst reads and the operate/commit timer.
module tensor_burst_sequencer
  import tensor_pkg::*;
#(
  parameter int unsigned N               = 3,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned WRITE_LANES     = 4,
  parameter int unsigned READ_LANES      = 2,
  parameter int unsigned COMPUTE_LATENCY = 4
) (
  input logic                    clock_in,
  input logic                    reset_in,
  tensor_burst_sequencer_if.slave bus
);

  localparam int unsigned NN  = N * N;
  localparam int unsigned WB  = ceil_div(2 * NN, WRITE_LANES);
  localparam int unsigned RB  = ceil_div(NN, READ_LANES);
  localparam int unsigned BW  = idx_width(WB);
  localparam int unsigned WCW = $clog2(WB + 1);
  localparam int unsigned RCW = $clog2(RB + 1);
  localparam int unsigned CCW = $clog2(COMPUTE_LATENCY + 1);

  seq_state_t     state_q, state_d;
  logic [2:0]     select_q, select_d;
  logic [CCW-1:0] cmp_cnt_q, cmp_cnt_d;
  logic [WCW-1:0] wr_count;
  logic [RCW-1:0] rd_count;
  logic           wr_done, rd_done;
  logic           in_idle, abort_act, cnt_clear;
  logic           wr_active, rd_active, wr_fire, rd_fire, wr_last, rd_last;

  assign in_idle   = (state_q == ST_IDLE);
  assign abort_act = bus.abort_in && !in_idle;
  assign cnt_clear = in_idle || abort_act;
  assign wr_active = (state_q == ST_WRITE) || (state_q == ST_RDWR);
  assign rd_active = (state_q == ST_READ)  || (state_q == ST_RDWR);

  // Abort masks both handshakes so neither side sees a transfer in that cycle.
  assign bus.write_data_ready_out = wr_active && !wr_done && !abort_act;
  assign bus.read_data_valid_out  = rd_active && !rd_done && !abort_act;
  assign wr_fire = bus.write_data_valid_in && bus.write_data_ready_out;
  assign rd_fire = bus.read_data_valid_out && bus.read_data_ready_in;
  assign wr_last = wr_fire && (wr_count == WCW'(WB - 1));
  assign rd_last = rd_fire && (rd_count == RCW'(RB - 1));

  burst_beat_counter #(.LIMIT(WB)) u_wr_cnt (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .enable_in (wr_fire),
    .clear_in  (cnt_clear),
    .count_out (wr_count),
    .done_out  (wr_done)
  );

  burst_beat_counter #(.LIMIT(RB)) u_rd_cnt (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .enable_in (rd_fire),
    .clear_in  (cnt_clear),
    .count_out (rd_count),
    .done_out  (rd_done)
  );

  assign bus.cmd_ready_out         = in_idle;
  assign bus.busy_out              = !in_idle;
  assign bus.rf_write_enable_out   = wr_fire;
  assign bus.rf_write_beat_out     = wr_count[BW-1:0];
  assign bus.rf_write_data_out     = bus.write_data_in;
  assign bus.core_start_out        = (state_q == ST_COMPUTE) && (cmp_cnt_q == '0);
  assign bus.core_select_out       = select_q;
  assign bus.bulk_write_enable_out = (state_q == ST_COMMIT) && !bus.abort_in;

  always_comb begin
    bus.rf_write_lane_mask_out = '0;
    for (int unsigned k = 0; k < WRITE_LANES; k++) begin
      bus.rf_write_lane_mask_out[k] = (32'(wr_count) * WRITE_LANES + k) < 2 * NN;
    end
  end

  // Lanes past the last result element read as zero.
  always_comb begin
    bus.read_data_out = '0;
    for (int unsigned k = 0; k < READ_LANES; k++) begin
      for (int unsigned e = 0; e < NN; e++) begin
        if (32'(rd_count) * READ_LANES + k == e) begin
          bus.read_data_out[k*DATA_WIDTH +: DATA_WIDTH] = bus.result_in[e*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    select_d  = select_q;
    cmp_cnt_d = cmp_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_in) begin
          select_d  = bus.cmd_select_in;
          cmp_cnt_d = '0;
          case (cmd_op_t'(bus.cmd_op_in))
            CMD_READ:    state_d = ST_READ;
            CMD_WRITE:   state_d = ST_WRITE;
            CMD_RDWR:    state_d = ST_RDWR;
            CMD_OPERATE: state_d = ST_COMPUTE;
            default:     state_d = ST_IDLE;
          endcase
        end
      end
      ST_WRITE:   if (wr_last) state_d = ST_IDLE;
      ST_READ:    if (rd_last) state_d = ST_IDLE;
      ST_RDWR:    if ((wr_done || wr_last) && (rd_done || rd_last)) state_d = ST_IDLE;
      ST_COMPUTE: begin
        if (cmp_cnt_q == CCW'(COMPUTE_LATENCY)) begin
          state_d = ST_COMMIT;
        end else begin
          cmp_cnt_d = cmp_cnt_q + 1'b1;
        end
      end
      ST_COMMIT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort_act) begin
      state_d   = ST_IDLE;
      cmp_cnt_d = '0;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= ST_IDLE;
      select_q  <= '0;
      cmp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      select_q  <= select_d;
      cmp_cnt_q <= cmp_cnt_d;
    end
  end

endmodule

// File: tb/tb_tensor_burst_sequencer.sv
// Scoreboard bench: stimulus queues expected beats/events, a negedge monitor compares them.
module tb_tensor_burst_sequencer;
  import tensor_pkg::*;

  localparam int unsigned N   = 3;
  localparam int unsigned DW  = 8;
  localparam int unsigned WL  = 4;
  localparam int unsigned RL  = 2;
  localparam int unsigned LAT = 4;
  localparam int unsigned NN  = N * N;
  localparam int unsigned NE  = 2 * NN;
  localparam int unsigned WB  = ceil_div(NE, WL);
  localparam int unsigned RB  = ceil_div(NN, RL);

  typedef struct {
    int unsigned       beat;
    logic [WL-1:0]     mask;
    logic [WL*DW-1:0]  data;
  } wexp_t;

  typedef struct {
    bit          commit;
    int unsigned cyc;
    logic [2:0]  sel;
  } eexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  wexp_t            wq[$];
  logic [RL*DW-1:0] rq[$];
  eexp_t            eq[$];
  wexp_t            wh;
  eexp_t            eh;

  tensor_burst_sequencer_if #(.N(N), .DATA_WIDTH(DW), .WRITE_LANES(WL), .READ_LANES(RL)) bus ();

  tensor_burst_sequencer #(
    .N(N), .DATA_WIDTH(DW), .WRITE_LANES(WL), .READ_LANES(RL), .COMPUTE_LATENCY(LAT)
  ) dut (
    .clock_in (clk),
    .reset_in (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rf_write_enable_out) begin
        if (wq.size() == 0) miss("wr_unexpected");
        else begin
          wh = wq.pop_front();
          chk("wr_beat", 64'(bus.rf_write_beat_out), 64'(wh.beat));
          chk("wr_mask", 64'(bus.rf_write_lane_mask_out), 64'(wh.mask));
          chk("wr_data", 64'(bus.rf_write_data_out), 64'(wh.data));
        end
      end
      if (bus.read_data_valid_out) begin
        if (rq.size() == 0) miss("rd_unexpected");
        else begin
          chk("rd_data", 64'(bus.read_data_out), 64'(rq[0]));
          if (bus.read_data_ready_in) void'(rq.pop_front());
        end
      end
      if (bus.core_start_out) begin
        if (eq.size() == 0) miss("start_unexpected");
        else begin
          eh = eq.pop_front();
          chk("start_kind", 64'(eh.commit), 64'(0));
          chk("start_cycle", 64'(cyc), 64'(eh.cyc));
          chk("start_select", 64'(bus.core_select_out), 64'(eh.sel));
        end
      end
      if (bus.bulk_write_enable_out) begin
        if (eq.size() == 0) miss("commit_unexpected");
        else begin
          eh = eq.pop_front();
          chk("commit_kind", 64'(eh.commit), 64'(1));
          chk("commit_cycle", 64'(cyc), 64'(eh.cyc));
          chk("commit_select", 64'(bus.core_select_out), 64'(eh.sel));
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] sel, output int unsigned acc);
    @(posedge clk); #1;
    bus.cmd_valid_in  = 1'b1;
    bus.cmd_op_in     = op;
    bus.cmd_select_in = sel;
    @(negedge clk);
    chk("cmd_ready", 64'(bus.cmd_ready_out), 64'(1));
    acc = cyc;
    @(posedge clk); #1;
    bus.cmd_valid_in = 1'b0;
  endtask

  // wmode: 0 valid always, 1 random, 2 one-cycle gaps before beats 1 and 3.
  // rmode: 0 ready always, 1 random, 3 alternating starting high (results 1..N*N).
  task automatic run_xfer(input logic [1:0] op, input int wmode, input int rmode,
                          input int rst_after, input bit inject,
                          input int exp_w, input int exp_r, input int exp_idle);
    logic [DW-1:0]    el[NE];
    logic [DW-1:0]    res[NN];
    logic [WL*DW-1:0] wd[WB];
    logic [RL*DW-1:0] rw;
    wexp_t            w;
    bit               do_w, do_r, g1, g3, vw, rr;
    int unsigned      acc, wb, rb, rel, budget, e;
    int               last_w, last_r;
    do_w = (op == 2'd1) || (op == 2'd2);
    do_r = (op == 2'd0) || (op == 2'd2);
    g1 = 0; g3 = 0; last_w = -1; last_r = -1;
    for (int unsigned i = 0; i < NE; i++) el[i] = (wmode == 0) ? DW'(i + 1) : DW'($urandom);
    for (int unsigned i = 0; i < NN; i++) begin
      res[i] = (rmode == 3) ? DW'(i + 1) : DW'($urandom);
      bus.result_in[i*DW +: DW] = res[i];
    end
    for (int unsigned b = 0; b < WB; b++) begin
      w.beat = b; w.mask = '0; w.data = '0;
      for (int unsigned k = 0; k < WL; k++) begin
        e = b * WL + k;
        if (e < NE) begin
          w.mask[k] = 1'b1;
          w.data[k*DW +: DW] = el[e];
        end else begin
          w.data[k*DW +: DW] = DW'($urandom);
        end
      end
      wd[b] = w.data;
      if (do_w) wq.push_back(w);
    end
    if (do_r) begin
      for (int unsigned b = 0; b < RB; b++) begin
        rw = '0;
        for (int unsigned k = 0; k < RL; k++) begin
          e = b * RL + k;
          if (e < NN) rw[k*DW +: DW] = res[e];
        end
        rq.push_back(rw);
      end
    end
    issue(op, 3'($urandom), acc);
    wb = 0; rb = 0; budget = 0;
    while (((do_w && wb < WB) || (do_r && rb < RB)) && budget < 100) begin
      rel = cyc - acc;
      case (wmode)
        0:       vw = 1'b1;
        1:       vw = ($urandom_range(0, 3) != 0);
        default: begin
          vw = 1'b1;
          if (wb == 1 && !g1) begin vw = 1'b0; g1 = 1; end
          if (wb == 3 && !g3) begin vw = 1'b0; g3 = 1; end
        end
      endcase
      vw = vw && do_w && (wb < WB);
      case (rmode)
        0:       rr = 1'b1;
        1:       rr = ($urandom_range(0, 2) != 0);
        default: rr = (rel % 2 == 1);
      endcase
      bus.write_data_valid_in = vw;
      bus.write_data_in       = (wb < WB) ? wd[wb] : '0;
      bus.read_data_ready_in  = rr;
      if (inject && wb == 2) begin
        bus.cmd_valid_in = 1'b1;
        bus.cmd_op_in    = 2'd3;
      end else begin
        bus.cmd_valid_in = 1'b0;
      end
      @(negedge clk);
      if (vw && bus.write_data_ready_out) begin last_w = int'(rel); wb++; end
      if (do_r && rr && bus.read_data_valid_out) begin last_r = int'(rel); rb++; end
      if (rst_after >= 0 && int'(wb) == rst_after) begin
        @(posedge clk); #1;
        bus.write_data_valid_in = 1'b1;
        bus.write_data_in       = wd[wb];
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 64'(bus.busy_out), 64'(0));
        chk("rst_cmd_ready", 64'(bus.cmd_ready_out), 64'(1));
        chk("rst_wr_strobe", 64'(bus.rf_write_enable_out), 64'(0));
        chk("rst_wr_ready", 64'(bus.write_data_ready_out), 64'(0));
        chk("rst_wr_beat", 64'(bus.rf_write_beat_out), 64'(0));
        chk("rst_select", 64'(bus.core_select_out), 64'(0));
        wq.delete();
        rq.delete();
        bus.write_data_valid_in = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
      budget++;
    end
    bus.write_data_valid_in = 1'b0;
    bus.read_data_ready_in  = 1'b0;
    bus.cmd_valid_in        = 1'b0;
    if (budget >= 100) miss("xfer_timeout");
    @(negedge clk);
    rel = cyc - acc;
    chk("xfer_cmd_ready", 64'(bus.cmd_ready_out), 64'(1));
    chk("xfer_busy", 64'(bus.busy_out), 64'(0));
    chk("wq_drained", 64'(wq.size()), 64'(0));
    chk("rq_drained", 64'(rq.size()), 64'(0));
    if (exp_w >= 0) chk("wr_end_cycle", 64'(last_w), 64'(exp_w));
    if (exp_r >= 0) chk("rd_end_cycle", 64'(last_r), 64'(exp_r));
    if (exp_idle >= 0) chk("idle_cycle", 64'(rel), 64'(exp_idle));
  endtask

  task automatic do_op(input logic [2:0] sel, input int abort_rel);
    int unsigned acc;
    eexp_t       ev;
    issue(2'd3, sel, acc);
    ev = '{commit: 1'b0, cyc: acc + 1, sel: sel};
    eq.push_back(ev);
    if (abort_rel < 0) begin
      ev = '{commit: 1'b1, cyc: acc + LAT + 2, sel: sel};
      eq.push_back(ev);
    end
    for (int unsigned rel = 1; rel <= LAT + 3; rel++) begin
      bus.abort_in = (int'(rel) == abort_rel);
      @(negedge clk);
      if (abort_rel >= 0 && int'(rel) == abort_rel + 1) chk("abort_to_idle", 64'(bus.busy_out), 64'(0));
      if (abort_rel < 0 && rel == LAT + 2) chk("commit_busy", 64'(bus.busy_out), 64'(1));
      @(posedge clk); #1;
    end
    bus.abort_in = 1'b0;
    chk("op_events_done", 64'(eq.size()), 64'(0));
    chk("op_cmd_ready", 64'(bus.cmd_ready_out), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] op;
    bus.cmd_valid_in        = 1'b0;
    bus.cmd_op_in           = '0;
    bus.cmd_select_in       = '0;
    bus.abort_in            = 1'b0;
    bus.write_data_valid_in = 1'b0;
    bus.write_data_in       = '0;
    bus.result_in           = '0;
    bus.read_data_ready_in  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", 64'(bus.cmd_ready_out), 64'(1));
    chk("reset_busy", 64'(bus.busy_out), 64'(0));
    chk("reset_wr_ready", 64'(bus.write_data_ready_out), 64'(0));
    chk("reset_rd_valid", 64'(bus.read_data_valid_out), 64'(0));
    chk("reset_start", 64'(bus.core_start_out), 64'(0));
    chk("reset_bulk", 64'(bus.bulk_write_enable_out), 64'(0));
    chk("reset_select", 64'(bus.core_select_out), 64'(0));
    chk("reset_wr_beat", 64'(bus.rf_write_beat_out), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    run_xfer(2'd1, 0, 0, -1, 1'b1, 5, -1, 6);
    run_xfer(2'd0, 0, 3, -1, 1'b0, -1, 9, 10);
    do_op(3'b010, -1);
    run_xfer(2'd2, 2, 0, -1, 1'b0, 7, 5, 8);
    do_op(3'($urandom), 2);
    run_xfer(2'd1, 0, 0, 3, 1'b0, -1, -1, -1);
    run_xfer(2'd1, 0, 0, -1, 1'b0, 5, -1, 6);

    repeat (14) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'd3) begin
        if ($urandom_range(0, 1) == 0) do_op(3'($urandom), -1);
        else do_op(3'($urandom), int'($urandom_range(2, LAT + 2)));
      end else begin
        run_xfer(op, 1, 1, -1, 1'b0, -1, -1, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
